mode6_sub_ctrl: RTL

//  Sequences the 4-lane mode-6 FP subtract stage of the softmax datapath: x[i] - b over a vector in buffer RAM.

---
 rtl/mode6_sub_ctrl_pkg.sv | 15 +
 rtl/mode6_sub.sv | 92 +++++++++
 rtl/mode6_sub_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mode6_sub_ctrl_pkg.sv
// Shared constants for the mode-6 subtract stage: FP16 number format, lane count
// and the controller FSM state encoding.
package mode6_sub_ctrl_pkg;
  localparam int DATAWIDTH = 16;
  localparam int EXPONENT  = 5;
  localparam int MANTISSA  = 10;
  localparam int LANES     = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mode6_sub.sv
// Four-lane combinational FP16 subtract z[i] = a[i] - b, round-to-nearest-even,
// subnormals handled, NaN/Inf propagated.
module mode6_sub
  import mode6_sub_ctrl_pkg::*;
(
  input  logic [LANES*DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0]       b,
  output logic [LANES*DATAWIDTH-1:0] z
);
  localparam int SW = MANTISSA + 4;
  localparam logic [EXPONENT+1:0] E_ONE = {{(EXPONENT+1){1'b0}}, 1'b1};
  localparam logic [EXPONENT+1:0] E_TOP = {2'b00, {EXPONENT{1'b1}}};

  function automatic logic [DATAWIDTH-1:0] fp_sub(input logic [DATAWIDTH-1:0] x,
                                                  input logic [DATAWIDTH-1:0] y);
    logic sx, sy, sl, ss;
    logic [EXPONENT-1:0] ex, ey, el, es, d;
    logic [MANTISSA-1:0] fx, fy;
    logic [MANTISSA:0] ml, ms;
    logic [3*SW-1:0] sh;
    logic [SW-1:0] al, as, al_s;
    logic [SW:0] r;
    logic [EXPONENT+1:0] e;
    logic [MANTISSA+1:0] m;
    logic inc, x_inf, y_inf, x_nan, y_nan;
    logic [DATAWIDTH-1:0] res;
    sx = x[DATAWIDTH-1];
    ex = x[DATAWIDTH-2:MANTISSA];
    fx = x[MANTISSA-1:0];
    sy = ~y[DATAWIDTH-1];
    ey = y[DATAWIDTH-2:MANTISSA];
    fy = y[MANTISSA-1:0];
    x_inf = (&ex) && !(|fx);
    y_inf = (&ey) && !(|fy);
    x_nan = (&ex) && (|fx);
    y_nan = (&ey) && (|fy);
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) begin
      res = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
    end else if (x_inf) begin
      res = {sx, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
    end else if (y_inf) begin
      res = {sy, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
    end else begin
      if ({ex, fx} >= {ey, fy}) begin
        sl = sx; el = ex; ml = {|ex, fx};
        ss = sy; es = ey; ms = {|ey, fy};
      end else begin
        sl = sy; el = ey; ml = {|ey, fy};
        ss = sx; es = ex; ms = {|ex, fx};
      end
      // subnormals share the exponent of the smallest normal
      el = el | {{(EXPONENT-1){1'b0}}, ~|el};
      es = es | {{(EXPONENT-1){1'b0}}, ~|es};
      d  = el - es;
      sh = {ms, 3'b000, {(2*SW){1'b0}}} >> d;
      al_s = sh[3*SW-1:2*SW];
      as = {al_s[SW-1:1], al_s[0] | (|sh[2*SW-1:0])};
      al = {ml, 3'b000};
      if (sl == ss) r = {1'b0, al} + {1'b0, as};
      else          r = {1'b0, al} - {1'b0, as};
      e = {2'b00, el};
      if (r == '0) begin
        res = {(sl == ss) ? sl : 1'b0, {(DATAWIDTH-1){1'b0}}};
      end else begin
        if (r[SW]) begin
          r = {1'b0, r[SW:2], r[1] | r[0]};
          e = e + E_ONE;
        end else begin
          for (int i = 0; i < SW; i++) begin
            if (!r[SW-1] && (e > E_ONE)) begin
              r = {r[SW-1:0], 1'b0};
              e = e - E_ONE;
            end
          end
        end
        inc = r[2] & (r[1] | r[0] | r[3]);
        m = {1'b0, r[SW-1:3]} + {{(MANTISSA+1){1'b0}}, inc};
        if (m[MANTISSA+1]) begin
          m = m >> 1;
          e = e + E_ONE;
        end
        if (e >= E_TOP) res = {sl, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
        else res = {sl, m[MANTISSA] ? e[EXPONENT-1:0] : {EXPONENT{1'b0}}, m[MANTISSA-1:0]};
      end
    end
    return res;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign z[l*DATAWIDTH +: DATAWIDTH] = fp_sub(a[l*DATAWIDTH +: DATAWIDTH], b);
  end
endmodule

// File: rtl/mode6_sub_ctrl.sv
// Mode-6 subtract sequencer: streams RAM words through mode6_sub into a small result
// FIFO and writes back with backpressure. MODE6_SUB_CTRL_PERF_EN adds stall_cnt.
module mode6_sub_ctrl
  import mode6_sub_ctrl_pkg::*;
#(
  parameter int ADDRW      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [ADDRW:0]               len,
  input  logic [ADDRW-1:0]             rd_base,
  input  logic [ADDRW-1:0]             wr_base,
  input  logic [DATAWIDTH-1:0]         b_inp,
  output logic                         mem_rd_en,
  output logic [ADDRW-1:0]             mem_rd_addr,
  input  logic [LANES*DATAWIDTH-1:0]   mem_rd_data,
  output logic                         mem_wr_en,
  output logic [ADDRW-1:0]             mem_wr_addr,
  output logic [LANES*DATAWIDTH-1:0]   mem_wr_data,
  input  logic                         mem_wr_ready,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   dbg_state
`ifdef MODE6_SUB_CTRL_PERF_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = LANES * DATAWIDTH;
  localparam logic [ADDRW:0] LEN_ONE = {{ADDRW{1'b0}}, 1'b1};

  // Handshake: a write transfers on a cycle where mem_wr_en & mem_wr_ready are both
  // high; while stalled, mem_wr_en/addr/data hold. Reads have no handshake and return
  // data exactly one cycle after mem_rd_en.
  state_t              state;
  logic [DATAWIDTH-1:0] b_q;
  logic [ADDRW-1:0]    rd_addr, wr_addr;
  logic [ADDRW:0]      rd_left;
  logic                inflight;
  logic [WW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wptr, rptr;
  logic [PW:0]         count, count_nxt;
  logic [PW+1:0]       credit_used;
  logic [WW-1:0]       sub_z;
  logic                push, pop, fifo_empty, rd_go;

  mode6_sub u_sub (
    .a (mem_rd_data),
    .b (b_q),
    .z (sub_z)
  );

  assign push       = inflight;
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && mem_wr_ready;
  assign count_nxt  = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  // A word leaving this cycle frees its slot in time for a read issued now,
  // which keeps the unstalled stream at one word per cycle without overflow.
  assign credit_used = {1'b0, count} + {{(PW+1){1'b0}}, inflight} - {{(PW+1){1'b0}}, pop};
  assign rd_go       = (state == S_RUN) && (credit_used < (PW+2)'(FIFO_DEPTH));

  assign mem_rd_en   = rd_go;
  assign mem_rd_addr = rd_addr;
  assign mem_wr_en   = !fifo_empty;
  assign mem_wr_addr = wr_addr;
  assign mem_wr_data = fifo_empty ? '0 : fifo_mem[rptr];
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      b_q      <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      rd_left  <= '0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= rd_go;
      count    <= count_nxt;
      if (push) begin
        fifo_mem[wptr] <= sub_z;
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr    <= rptr + 1'b1;
        wr_addr <= wr_addr + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            b_q     <= b_inp;
            rd_addr <= rd_base;
            wr_addr <= wr_base;
            rd_left <= len;
            state   <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_go) begin
            rd_addr <= rd_addr + 1'b1;
            rd_left <= rd_left - LEN_ONE;
            if (rd_left == LEN_ONE) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_nxt == '0) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MODE6_SUB_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_cnt <= '0;
    end else if (mem_wr_en && !mem_wr_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule
